life_frame_streamer: RTL and testbench

Snapshot-and-stream reader for the toroidal life-cell grid. On request it captures the grid's full `cells` vector in a single cycle, then emits it one row per transfer over a valid/ready stream, so a host, UART bridge or display driver can consume generations without stalling the grid. It connects directly to the grid's `cells` output and drives nothing back into the grid.

---
 rtl/life_pkg.sv | 22 ++
 rtl/life_popcount.sv | 24 ++
 rtl/life_frame_streamer.sv | 129 ++++++++++++
 tb/tb_life_frame_streamer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared types and width helper for the life-grid frame
//               streamer and its popcount sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    // Streamer control states: waiting for a snapshot, or sending its rows.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Bits needed to index v items; never less than one so N=1 still has a port.
    function automatic int width_of(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_popcount.sv
`default_nettype none
// ============================================================================
// Module      : life_popcount
// Description : Purely combinational count of set bits in a W-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
module life_popcount #(
    parameter int W  = 16,
    parameter int OW = 5
) (
    input  logic [W-1:0]  i_bits,
    output logic [OW-1:0] o_count
);

    // Sum of all bits; written as an accumulation, reshaped into a tree by synthesis.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + OW'(i_bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/life_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : life_frame_streamer
// Description : Captures the life grid's cells vector on request and streams
//               it out one row per valid/ready transfer, chaining frames with
//               no bubble when a new request lands on the last-row handshake.
//               Optional macro LIFE_POPCOUNT_EN adds a pop_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module life_frame_streamer
    import life_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [N*N-1:0]                  cells,
    input  logic                            snap,
    output logic [N-1:0]                    row_data,
    output logic [width_of(N)-1:0]          row_idx,
    output logic                            row_valid,
    input  logic                            row_ready,
    output logic                            row_first,
    output logic                            row_last,
    output logic                            busy,
    output logic                            overrun,
`ifdef LIFE_POPCOUNT_EN
    output logic [width_of(N*N+1)-1:0]      pop_count,
`endif
    output logic [CW-1:0]                   frame_count
);

    localparam int               c_IW   = width_of(N);
    localparam logic [c_IW-1:0]  c_LAST = c_IW'(N - 1);

    state_t            r_state;
    logic [N*N-1:0]    r_shadow;
    logic [c_IW-1:0]   r_ptr;
    logic [CW-1:0]     r_frame_count;
    logic              r_overrun;

    logic [N-1:0]      w_rows [N];
    logic              w_valid;
    logic              w_hs;
    logic              w_last;
    logic              w_last_hs;
    logic              w_latch;

    // Slice the shadow register into rows so the pointer selects a whole row.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rows
            assign w_rows[gi] = r_shadow[gi*N +: N];
        end
    endgenerate

    // Valid comes straight from the state flop, so it never depends on ready.
    assign w_valid   = (r_state == ST_SEND);
    assign w_hs      = w_valid && row_ready;
    assign w_last    = (r_ptr == c_LAST);
    assign w_last_hs = w_hs && w_last;
    // A snapshot is taken from idle, or on the final handshake to chain frames.
    assign w_latch   = snap && ((r_state == ST_IDLE) || w_last_hs);

    // Control path: capture, row pointer advance, frame counting and overrun flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_shadow      <= '0;
            r_ptr         <= '0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= w_valid && snap && !w_last_hs;
            if (w_latch) begin
                r_shadow <= cells;
                r_ptr    <= '0;
                r_state  <= ST_SEND;
            end else if (w_hs) begin
                if (w_last) begin
                    r_ptr   <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_ptr <= r_ptr + c_IW'(1);
                end
            end
            if (w_last_hs) begin
                r_frame_count <= r_frame_count + CW'(1);
            end
        end
    end

`ifdef LIFE_POPCOUNT_EN
    localparam int c_PW = width_of(N*N + 1);

    logic [c_PW-1:0] w_pop;
    logic [c_PW-1:0] r_pop;

    life_popcount #(
        .W  (N*N),
        .OW (c_PW)
    ) u_popcount (
        .i_bits  (cells),
        .o_count (w_pop)
    );

    // Count is captured alongside the snapshot so it always matches the frame in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pop <= '0;
        end else if (w_latch) begin
            r_pop <= w_pop;
        end
    end

    assign pop_count = r_pop;
`endif

    assign row_valid   = w_valid;
    assign busy        = w_valid;
    assign row_idx     = r_ptr;
    assign row_data    = w_rows[r_ptr];
    assign row_first   = w_valid && (r_ptr == '0);
    assign row_last    = w_valid && w_last;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_life_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_frame_streamer
// Description : Directed self-checking bench for life_frame_streamer (N=4,
//               CW=4). Covers LIFE_POPCOUNT_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_frame_streamer;

    localparam int N  = 4;
    localparam int CW = 4;

    logic            clk;
    logic            nrst;
    logic [N*N-1:0]  cells;
    logic            snap;
    logic [N-1:0]    row_data;
    logic [1:0]      row_idx;
    logic            row_valid;
    logic            row_ready;
    logic            row_first;
    logic            row_last;
    logic            busy;
    logic            overrun;
    logic [CW-1:0]   frame_count;
`ifdef LIFE_POPCOUNT_EN
    logic [4:0]      pop_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    life_frame_streamer #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cells       (cells),
        .snap        (snap),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_first   (row_first),
        .row_last    (row_last),
        .busy        (busy),
        .overrun     (overrun),
`ifdef LIFE_POPCOUNT_EN
        .pop_count   (pop_count),
`endif
        .frame_count (frame_count)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected row r of a 4x4 snapshot value.
    function automatic logic [3:0] row_of(input logic [15:0] v, input int r);
        logic [15:0] s;
        s = v >> (4 * r);
        return s[3:0];
    endfunction

    // Full row check: valid, index, data, first/last flags.
    task automatic check_row(input string tag, input logic [15:0] v, input int r);
        check({tag, ".valid"}, 32'(row_valid), 32'd1);
        check({tag, ".idx"},   32'(row_idx),   32'(r));
        check({tag, ".data"},  32'(row_data),  32'(row_of(v, r)));
        check({tag, ".first"}, 32'(row_first), 32'(r == 0));
        check({tag, ".last"},  32'(row_last),  32'(r == 3));
    endtask

    initial begin
        logic [15:0] pat;
        logic [15:0] sv;
        int          exp_idx;
        int          delivered;

        nrst      = 1'b0;
        cells     = '0;
        snap      = 1'b0;
        row_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst.valid", 32'(row_valid),   32'd0);
        check("rst.busy",  32'(busy),        32'd0);
        check("rst.ovr",   32'(overrun),     32'd0);
        check("rst.first", 32'(row_first),   32'd0);
        check("rst.last",  32'(row_last),    32'd0);
        check("rst.idx",   32'(row_idx),     32'd0);
        check("rst.data",  32'(row_data),    32'd0);
        check("rst.fc",    32'(frame_count), 32'd0);
        nrst = 1'b1;
        tick();

        // Single frame with ready held high
        cells     = 16'hA5C3;
        snap      = 1'b1;
        row_ready = 1'b1;
        tick();
        snap = 1'b0;
        check_row("sf.r0", 16'hA5C3, 0);
        check("sf.busy", 32'(busy), 32'd1);
        tick();
        check_row("sf.r1", 16'hA5C3, 1);
        tick();
        check_row("sf.r2", 16'hA5C3, 2);
        tick();
        check_row("sf.r3", 16'hA5C3, 3);
        tick();
        check("sf.idle", 32'(row_valid),   32'd0);
        check("sf.busy0",32'(busy),        32'd0);
        check("sf.fc",   32'(frame_count), 32'd1);

        // Backpressure with cells changing after the snapshot
        sv        = 16'h1234;
        cells     = sv;
        snap      = 1'b1;
        row_ready = 1'b0;
        tick();
        snap      = 1'b0;
        cells     = 16'hFFFF;
        pat       = 16'b0110_1001_0100_1101;
        exp_idx   = 0;
        delivered = 0;
        for (int k = 0; k < 16 && delivered < 4; k++) begin
            row_ready = pat[k];
            check_row($sformatf("bp.k%0d", k), sv, exp_idx);
            tick();
            if (pat[k]) begin
                exp_idx++;
                delivered++;
            end
        end
        row_ready = 1'b0;
        check("bp.rows", 32'(delivered),   32'd4);
        check("bp.idle", 32'(row_valid),   32'd0);
        check("bp.fc",   32'(frame_count), 32'd2);

        // Overrun during row 1, then chaining on the last-row handshake
        cells     = 16'h8421;
        snap      = 1'b1;
        row_ready = 1'b1;
        tick();
        snap = 1'b0;
        check_row("ov.r0", 16'h8421, 0);
        tick();
        check_row("ov.r1", 16'h8421, 1);
        check("ov.pre", 32'(overrun), 32'd0);
        snap      = 1'b1;
        row_ready = 1'b0;
        tick();
        snap      = 1'b0;
        row_ready = 1'b1;
        check("ov.pulse", 32'(overrun), 32'd1);
        check_row("ov.hold", 16'h8421, 1);
        tick();
        check("ov.end", 32'(overrun), 32'd0);
        check_row("ov.r2", 16'h8421, 2);
        tick();
        check_row("ov.r3", 16'h8421, 3);
        cells = 16'h0F0F;
        snap  = 1'b1;
        tick();
        snap = 1'b0;
        check_row("ch.r0", 16'h0F0F, 0);
        check("ch.ovr", 32'(overrun),     32'd0);
        check("ch.fc",  32'(frame_count), 32'd3);
        tick();
        check_row("ch.r1", 16'h0F0F, 1);
        tick();
        check_row("ch.r2", 16'h0F0F, 2);
        tick();
        check_row("ch.r3", 16'h0F0F, 3);
        tick();
        check("ch.idle", 32'(row_valid),   32'd0);
        check("ch.fc2",  32'(frame_count), 32'd4);

        // Reset asserted during row 2
        cells = 16'hBEEF;
        snap  = 1'b1;
        tick();
        snap = 1'b0;
        check_row("rm.r0", 16'hBEEF, 0);
        tick();
        tick();
        check_row("rm.r2", 16'hBEEF, 2);
        nrst = 1'b0;
        #1;
        check("rm.valid", 32'(row_valid),   32'd0);
        check("rm.busy",  32'(busy),        32'd0);
        check("rm.first", 32'(row_first),   32'd0);
        check("rm.last",  32'(row_last),    32'd0);
        check("rm.idx",   32'(row_idx),     32'd0);
        check("rm.data",  32'(row_data),    32'd0);
        check("rm.ovr",   32'(overrun),     32'd0);
        check("rm.fc",    32'(frame_count), 32'd0);
        tick();
        nrst  = 1'b1;
        tick();
        cells = 16'h00F0;
        snap  = 1'b1;
        tick();
        snap = 1'b0;
        check_row("rr.r0", 16'h00F0, 0);
        tick();
        check_row("rr.r1", 16'h00F0, 1);
        tick();
        tick();
        check_row("rr.r3", 16'h00F0, 3);
        tick();
        check("rr.idle", 32'(row_valid),   32'd0);
        check("rr.fc",   32'(frame_count), 32'd1);

        // Counter wrap: 17 back-to-back frames from a fresh reset
        nrst = 1'b0;
        #1;
        check("wr.fc0", 32'(frame_count), 32'd0);
        tick();
        nrst  = 1'b1;
        tick();
        cells = 16'hC3A5;
        snap  = 1'b1;
        for (int f = 1; f <= 17; f++) begin
            for (int r = 0; r < 4; r++) begin
                tick();
                check_row($sformatf("wr.f%0d.r%0d", f, r), 16'hC3A5, r);
                check($sformatf("wr.f%0d.r%0d.ovr", f, r), 32'(overrun), 32'(r != 0));
                if (r == 0) begin
                    check($sformatf("wr.f%0d.fc", f), 32'(frame_count), 32'((f - 1) % 16));
                end
                if (f == 17 && r == 3) begin
                    snap = 1'b0;
                end
            end
        end
        tick();
        check("wr.idle", 32'(row_valid),   32'd0);
        check("wr.fc",   32'(frame_count), 32'd1);

`ifdef LIFE_POPCOUNT_EN
        // Population count captured with each snapshot
        cells = 16'hFFFF;
        snap  = 1'b1;
        tick();
        snap  = 1'b0;
        cells = 16'h0000;
        check("pc.v16", 32'(row_valid), 32'd1);
        check("pc.16",  32'(pop_count), 32'd16);
        tick();
        tick();
        tick();
        check("pc.16h", 32'(pop_count), 32'd16);
        tick();
        cells = 16'h0001;
        snap  = 1'b1;
        tick();
        snap  = 1'b0;
        cells = 16'hFFFF;
        check("pc.v1", 32'(row_valid), 32'd1);
        check("pc.1",  32'(pop_count), 32'd1);
        tick();
        tick();
        tick();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
